alu_cmd_issuer: RTL

Command-side driver for the team's 8-bit, 4-bit-opcode combinational ALU. Upstream requesters push {opcode, a, b} commands through a valid/ready port into a small FIFO. The block issues each command to the ALU operand/opcode ports, waits a fixed settle time, and captures the ALU result. It then returns the result to the requester through a valid/ready response port, one command in flight at a time, in order.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_cmd_fifo.sv | 60 ++++++
 rtl/alu_cmd_issuer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : shared ALU opcode, command and issuer FSM state types       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,  SUB   = 4'd1,  MUL   = 4'd2,  DIV   = 4'd3,
    AND   = 4'd4,  OR    = 4'd5,  NAND  = 4'd6,  NOR   = 4'd7,
    INC_A = 4'd8,  DEC_A = 4'd9,  XOR   = 4'd10, SHR   = 4'd11,
    SHL   = 4'd12, ADDC  = 4'd13, SUBB  = 4'd14, INC_B = 4'd15
  } alu_op_e;

  localparam logic [3:0] OP_DIV = 4'b0011;

  // Opcode kept as raw bits so FIFO storage needs no enum casts.
  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } issuer_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_cmd_fifo : synchronous FIFO of alu_cmd_t entries with occupancy   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  alu_cmd_t                 din,
  input  logic                     pop,
  output alu_cmd_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);

  alu_cmd_t           r_mem [DEPTH];
  logic [c_aw-1:0]    r_wr_ptr;
  logic [c_aw-1:0]    r_rd_ptr;
  logic [c_aw:0]      r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == (c_aw+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointers are log2(DEPTH) wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_cmd_issuer : queues ALU commands, issues one at a time, returns   |
// | results in order. Option: ALU_CMD_ISSUER_DIV0_CHECK_EN short-circuits |
// | divide-by-zero. Revision: 1.0                                         |
// +----------------------------------------------------------------------+
module alu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_opcode,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_opcode,
  output logic       rsp_err,
  output logic       busy
);
  import alu_pkg::*;

  localparam int c_aw    = $clog2(DEPTH);
  localparam int c_cnt_w = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

  alu_cmd_t            w_wr_cmd;
  alu_cmd_t            w_head;
  logic                w_full;
  logic                w_empty;
  logic [c_aw:0]       w_count;
  logic                w_push;
  logic                w_pop;
  logic                w_issue;
  logic                w_capture;
  logic                w_shortcut;
  logic                w_div0;
  issuer_state_e       r_state;
  issuer_state_e       w_next_state;
  logic [c_cnt_w-1:0]  r_cnt;

  assign w_wr_cmd  = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
  assign cmd_ready = (w_count < (c_aw+1)'(DEPTH));
  assign w_push    = cmd_valid & cmd_ready;
  assign rsp_valid = (r_state == RESP);
  assign busy      = ~w_empty | (r_state != IDLE);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_wr_cmd),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

`ifdef ALU_CMD_ISSUER_DIV0_CHECK_EN
  assign w_div0 = (w_head.opcode == OP_DIV) && (w_head.b == 8'h00);
`else
  assign w_div0 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    w_shortcut   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_div0) begin
            w_shortcut   = 1'b1;
            w_next_state = RESP;
          end else begin
            w_issue      = 1'b1;
            w_next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == c_cnt_w'(1)) begin
          w_capture    = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ALU operands hold their last issued value between commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      r_cnt      <= '0;
      rsp_data   <= '0;
      rsp_opcode <= '0;
    end else begin
      if (w_issue) begin
        alu_a      <= w_head.a;
        alu_b      <= w_head.b;
        alu_opcode <= w_head.opcode;
        r_cnt      <= c_cnt_w'(ALU_LAT);
      end else if (r_state == WAIT) begin
        r_cnt      <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        rsp_data   <= alu_out;
        rsp_opcode <= alu_opcode;
      end else if (w_shortcut) begin
        rsp_data   <= 8'hFF;
        rsp_opcode <= OP_DIV;
      end
    end
  end

`ifdef ALU_CMD_ISSUER_DIV0_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_err <= 1'b0;
    else if (w_capture)  r_err <= 1'b0;
    else if (w_shortcut) r_err <= 1'b1;
  end
  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
`default_nettype wire
